// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the memory controller
// fetch port: request opcodes, access length, stall encoding and IF FSM states.
package if_prefetch_pkg;

   // Memory controller request opcodes
   localparam logic [1:0] MEM_NOP   = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;

   // Memory access length: byte=0, half=1, word=2
   localparam logic [1:0] MEM_WORD  = 2'b10;

   // Stall indication towards the rest of the pipeline
   localparam logic CHIP_STALL     = 1'b1;
   localparam logic CHIP_NOT_STALL = 1'b0;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,   // may issue a request
      IF_WAIT = 2'd1,   // request outstanding, data will be kept
      IF_DROP = 2'd2    // request outstanding, data will be discarded
   } if_state_e;

endpackage

// File: rtl/if_prefetch_queue.sv
// Circular FIFO holding fetched {pc, instruction} pairs. Pointers wrap modulo
// DEPTH (a power of two); flush empties the queue and wins over push/pop.
module if_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   // Never write into a full queue nor read from an empty one
   assign push_ok = push_i && (count_q != DEPTH_C);
   assign pop_ok  = pop_i  && (count_q != '0);

   // Next pointer and occupancy; a simultaneous push and pop keeps the count
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
         else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; data needs no reset because count gates its visibility
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with prefetch queue. Issues one aligned word request
// at a time to the memory controller, buffers results in if_queue and hands
// the head to decode via valid/ready. A jump flushes the queue; a request that
// is in flight when the jump arrives completes with its data discarded.
//
// Handshake: an entry transfers to decode in a cycle where out_valid and
// out_ready are both high, rdy_in is high and jump_en is low; out_valid never
// depends on out_ready.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int                    DEPTH      = 4,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   output logic [1:0]            memctl_op,
   output logic [1:0]            memctl_len,
   output logic [ADDR_WIDTH-1:0] memctl_addr,
   input  logic                  memctl_rdy,
   input  logic [INST_WIDTH-1:0] memctl_out,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [INST_WIDTH-1:0] out_ins,
   output logic                  stall,
   output logic [1:0]            dbg_state
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam int QW = ADDR_WIDTH + INST_WIDTH;

   if_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic                  push_d;
   logic                  q_push, q_pop, q_flush;
   logic [QW-1:0]         q_head;
   logic [CW-1:0]         q_count;
   logic                  unused_jump_lsb;

   // Target is word aligned; the low bits of jump_pc are intentionally dropped
   assign unused_jump_lsb = ^jump_pc[1:0];

   // Next-state logic: issue, completion, and jump redirect
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      push_d     = 1'b0;
      unique case (state_q)
         IF_IDLE: begin
            if (!jump_en && (q_count < DEPTH_C)) begin
               req_addr_d = fetch_pc_q;
               state_d    = IF_WAIT;
            end
         end
         IF_WAIT: begin
            if (jump_en) begin
               state_d = memctl_rdy ? IF_IDLE : IF_DROP;
            end else if (memctl_rdy) begin
               push_d     = 1'b1;
               fetch_pc_d = req_addr_q + ADDR_WIDTH'(4);
               state_d    = IF_IDLE;
            end
         end
         IF_DROP: begin
            if (memctl_rdy) state_d = IF_IDLE;
         end
         default: state_d = IF_IDLE;
      endcase
      if (jump_en) fetch_pc_d = {jump_pc[ADDR_WIDTH-1:2], 2'b00};
   end

   // State, PC and request address registers; rdy_in low freezes everything
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IF_IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else if (rdy_in) begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign out_valid = (q_count != '0);
   assign q_push    = rdy_in && push_d;
   assign q_flush   = rdy_in && jump_en;
   assign q_pop     = rdy_in && out_valid && out_ready && !jump_en;

   if_queue #(
      .DEPTH (DEPTH),
      .WIDTH (QW)
   ) u_queue (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .flush_i (q_flush),
      .data_i  ({req_addr_q, memctl_out}),
      .data_o  (q_head),
      .count_o (q_count)
   );

   // Memory port decoded from registered state only
   assign memctl_op   = (state_q == IF_IDLE) ? MEM_NOP : MEM_LOAD;
   assign memctl_len  = MEM_WORD;
   assign memctl_addr = req_addr_q;

   // Head presentation; zeros when the queue is empty
   assign out_pc    = out_valid ? q_head[QW-1:INST_WIDTH] : '0;
   assign out_ins   = out_valid ? q_head[INST_WIDTH-1:0]  : '0;
   assign stall     = out_valid ? CHIP_NOT_STALL : CHIP_STALL;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: two instances (RESET_PC 0 and 0xFFFFFFF8),
// each with a latency-programmable memory responder and pop/request monitors.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rdy = 1'b1;
  logic        out_ready = 1'b0, jump_en = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        out_ready2 = 1'b1, jump2_en = 1'b0;
  logic [31:0] jump2_pc = '0;

  logic [1:0]  memctl_op, memctl_len, dbg_state;
  logic [31:0] memctl_addr, memctl_out, out_pc, out_ins;
  logic        memctl_rdy, out_valid, stall;
  logic [1:0]  memctl_op2, memctl_len2, dbg_state2;
  logic [31:0] memctl_addr2, memctl_out2, out_pc2, out_ins2;
  logic        memctl_rdy2, out_valid2, stall2;

  int tests = 0, fails = 0;
  int lat = 3;
  logic [31:0] done_q[$], got_pc_q[$], got_ins_q[$], got2_q[$];

  if_prefetch #(.DEPTH(4), .ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
    .memctl_rdy(memctl_rdy), .memctl_out(memctl_out),
    .jump_en(jump_en), .jump_pc(jump_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .stall(stall), .dbg_state(dbg_state));

  if_prefetch #(.DEPTH(4), .ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .memctl_op(memctl_op2), .memctl_len(memctl_len2), .memctl_addr(memctl_addr2),
    .memctl_rdy(memctl_rdy2), .memctl_out(memctl_out2),
    .jump_en(jump2_en), .jump_pc(jump2_pc),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_pc(out_pc2), .out_ins(out_ins2),
    .stall(stall2), .dbg_state(dbg_state2));

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory responders ----------------
  logic mrdy_q, mrdy2_q;
  int   cnt_q, cnt2_q;

  always @(posedge clk) begin
    if (rst) begin
      mrdy_q <= 1'b0; cnt_q <= 0; memctl_out <= '0;
    end else if (rdy) begin
      mrdy_q <= 1'b0;
      if (memctl_op == MEM_LOAD && !mrdy_q) begin
        if (cnt_q >= lat - 1) begin
          mrdy_q <= 1'b1; cnt_q <= 0; memctl_out <= mem_word(memctl_addr);
        end else cnt_q <= cnt_q + 1;
      end
    end
  end
  assign memctl_rdy = mrdy_q & rdy;

  always @(posedge clk) begin
    if (rst) begin
      mrdy2_q <= 1'b0; cnt2_q <= 0; memctl_out2 <= '0;
    end else if (rdy) begin
      mrdy2_q <= 1'b0;
      if (memctl_op2 == MEM_LOAD && !mrdy2_q) begin
        if (cnt2_q >= lat - 1) begin
          mrdy2_q <= 1'b1; cnt2_q <= 0; memctl_out2 <= mem_word(memctl_addr2);
        end else cnt2_q <= cnt2_q + 1;
      end
    end
  end
  assign memctl_rdy2 = mrdy2_q & rdy;

  // ---------------- monitors (scoreboard capture) ----------------
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (memctl_rdy) done_q.push_back(memctl_addr);
      if (out_valid && out_ready && !jump_en) begin
        got_pc_q.push_back(out_pc);
        got_ins_q.push_back(out_ins);
      end
      if (out_valid2 && out_ready2 && !jump2_en) got2_q.push_back(out_pc2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; jump_en = 1'b0; jump2_en = 1'b0; rdy = 1'b1;
    tick(2);
    rst = 1'b0;
    done_q.delete(); got_pc_q.delete(); got_ins_q.delete(); got2_q.delete();
  endtask

  task automatic wait_got(int n, string tag);
    int i = 0;
    while (got_pc_q.size() < n && i < 400) begin tick(1); i++; end
    tests++;
    if (got_pc_q.size() < n) begin
      fails++; $display("FAIL %s_timeout: got %0d entries, need %0d", tag, got_pc_q.size(), n);
    end
  endtask

  task automatic wait_got2(int n, string tag);
    int i = 0;
    while (got2_q.size() < n && i < 400) begin tick(1); i++; end
    tests++;
    if (got2_q.size() < n) begin
      fails++; $display("FAIL %s_timeout: got %0d entries, need %0d", tag, got2_q.size(), n);
    end
  endtask

  task automatic wait_done(int n, string tag);
    int i = 0;
    while (done_q.size() < n && i < 400) begin tick(1); i++; end
    tests++;
    if (done_q.size() < n) begin
      fails++; $display("FAIL %s_timeout: %0d requests done, need %0d", tag, done_q.size(), n);
    end
  endtask

  task automatic wait_load(string tag);
    int i = 0;
    while (!(memctl_op == MEM_LOAD && memctl_rdy == 1'b0) && i < 100) begin tick(1); i++; end
    tests++;
    if (memctl_op !== MEM_LOAD) begin
      fails++; $display("FAIL %s_timeout: memctl_op %0h, need %0h", tag, memctl_op, MEM_LOAD);
    end
  endtask

  task automatic wait_load2(string tag);
    int i = 0;
    while (!(memctl_op2 == MEM_LOAD && memctl_rdy2 == 1'b0) && i < 100) begin tick(1); i++; end
    tests++;
    if (memctl_op2 !== MEM_LOAD) begin
      fails++; $display("FAIL %s_timeout: memctl_op2 %0h, need %0h", tag, memctl_op2, MEM_LOAD);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; out_ready = 1'b0; jump_en = 1'b0;
    tick(2);
    tests++; if (dbg_state !== IF_IDLE) begin fails++; $display("FAIL rst_state: got %0h want %0h", dbg_state, IF_IDLE); end
    tests++; if (memctl_op !== MEM_NOP) begin fails++; $display("FAIL rst_op: got %0h want %0h", memctl_op, MEM_NOP); end
    tests++; if (memctl_len !== MEM_WORD) begin fails++; $display("FAIL rst_len: got %0h want %0h", memctl_len, MEM_WORD); end
    tests++; if (memctl_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %0h want 0", memctl_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %0h want 0", out_pc); end
    tests++; if (out_ins !== 32'h0) begin fails++; $display("FAIL rst_ins: got %0h want 0", out_ins); end
    tests++; if (stall !== CHIP_STALL) begin fails++; $display("FAIL rst_stall: got %0b want %0b", stall, CHIP_STALL); end
    tests++; if (memctl_addr2 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL rst_addr2: got %0h want fffffff8", memctl_addr2); end
    rst = 1'b0;
    tick(1);
    tests++; if (memctl_op !== MEM_LOAD) begin fails++; $display("FAIL issue_op: got %0h want %0h", memctl_op, MEM_LOAD); end
    tests++; if (dbg_state !== IF_WAIT) begin fails++; $display("FAIL issue_state: got %0h want %0h", dbg_state, IF_WAIT); end
  endtask

  task automatic test_basic();
    lat = 3; out_ready = 1'b1;
    do_reset();
    wait_done(1, "basic_first");
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_lat_valid: got %0b want 1", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL basic_lat_pc: got %0h want 0", out_pc); end
    tests++; if (out_ins !== mem_word(32'h0)) begin fails++; $display("FAIL basic_lat_ins: got %0h want %0h", out_ins, mem_word(32'h0)); end
    tests++; if (stall !== CHIP_NOT_STALL) begin fails++; $display("FAIL basic_stall: got %0b want %0b", stall, CHIP_NOT_STALL); end
    wait_got(3, "basic");
    for (int k = 0; k < 3; k++) begin
      tests++; if (got_pc_q[k] !== 32'(k * 4)) begin fails++; $display("FAIL basic_pc%0d: got %0h want %0h", k, got_pc_q[k], k * 4); end
      tests++; if (got_ins_q[k] !== mem_word(32'(k * 4))) begin fails++; $display("FAIL basic_ins%0d: got %0h want %0h", k, got_ins_q[k], mem_word(32'(k * 4))); end
    end
  endtask

  task automatic test_full();
    lat = 2; out_ready = 1'b0;
    do_reset();
    tick(60);
    tests++; if (done_q.size() != 4) begin fails++; $display("FAIL full_count: got %0d want 4", done_q.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (done_q[k] !== 32'(k * 4)) begin fails++; $display("FAIL full_req%0d: got %0h want %0h", k, done_q[k], k * 4); end
    end
    tests++; if (memctl_op !== MEM_NOP) begin fails++; $display("FAIL full_op: got %0h want %0h", memctl_op, MEM_NOP); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL full_head: got %0h want 0", out_pc); end
    out_ready = 1'b1;
    wait_got(5, "full_drain");
    for (int k = 0; k < 5; k++) begin
      tests++; if (got_pc_q[k] !== 32'(k * 4)) begin fails++; $display("FAIL full_pc%0d: got %0h want %0h", k, got_pc_q[k], k * 4); end
    end
  endtask

  task automatic test_jump_wait();
    lat = 3; out_ready = 1'b0;
    do_reset();
    wait_done(1, "jw_first");
    wait_load("jw_load");
    tests++; if (memctl_addr !== 32'h4) begin fails++; $display("FAIL jw_addr: got %0h want 4", memctl_addr); end
    jump_en = 1'b1; jump_pc = 32'h103;
    tick(1);
    jump_en = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL jw_flush: got %0b want 0", out_valid); end
    tests++; if (dbg_state !== IF_DROP) begin fails++; $display("FAIL jw_state: got %0h want %0h", dbg_state, IF_DROP); end
    tests++; if (memctl_op !== MEM_LOAD) begin fails++; $display("FAIL jw_hold_op: got %0h want %0h", memctl_op, MEM_LOAD); end
    tests++; if (memctl_addr !== 32'h4) begin fails++; $display("FAIL jw_hold_addr: got %0h want 4", memctl_addr); end
    wait_done(2, "jw_drop");
    tests++; if (done_q[1] !== 32'h4) begin fails++; $display("FAIL jw_drop_addr: got %0h want 4", done_q[1]); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL jw_discard: got %0b want 0", out_valid); end
    out_ready = 1'b1;
    wait_got(1, "jw_target");
    tests++; if (got_pc_q[0] !== 32'h100) begin fails++; $display("FAIL jw_pc: got %0h want 100", got_pc_q[0]); end
    tests++; if (got_ins_q[0] !== mem_word(32'h100)) begin fails++; $display("FAIL jw_ins: got %0h want %0h", got_ins_q[0], mem_word(32'h100)); end
    tests++; if (done_q[2] !== 32'h100) begin fails++; $display("FAIL jw_req: got %0h want 100", done_q[2]); end
  endtask

  task automatic test_jump_rdy();
    int i = 0;
    lat = 3; out_ready = 1'b0;
    do_reset();
    wait_done(1, "jr_first");
    tick(1);
    while (memctl_rdy !== 1'b1 && i < 50) begin tick(1); i++; end
    tests++; if (memctl_rdy !== 1'b1) begin fails++; $display("FAIL jr_rdy_timeout: got %0b want 1", memctl_rdy); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL jr_pre_valid: got %0b want 1", out_valid); end
    jump_en = 1'b1; jump_pc = 32'h200; out_ready = 1'b1;
    got_pc_q.delete(); got_ins_q.delete();
    tick(1);
    jump_en = 1'b0; out_ready = 1'b0;
    tests++; if (got_pc_q.size() != 0) begin fails++; $display("FAIL jr_nopop: got %0d pops want 0", got_pc_q.size()); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL jr_nopush: got %0b want 0", out_valid); end
    tests++; if (dbg_state !== IF_IDLE) begin fails++; $display("FAIL jr_state: got %0h want %0h", dbg_state, IF_IDLE); end
    tick(1);
    tests++; if (memctl_op !== MEM_LOAD) begin fails++; $display("FAIL jr_op: got %0h want %0h", memctl_op, MEM_LOAD); end
    tests++; if (memctl_addr !== 32'h200) begin fails++; $display("FAIL jr_addr: got %0h want 200", memctl_addr); end
    out_ready = 1'b1;
    wait_got(1, "jr_target");
    tests++; if (got_pc_q[0] !== 32'h200) begin fails++; $display("FAIL jr_pc: got %0h want 200", got_pc_q[0]); end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] exp_addr;
    lat = 3; out_ready = 1'b1;
    do_reset();
    wait_got(2, "rs_pre");
    wait_load("rs_load");
    exp_addr = 32'(done_q.size() * 4);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      tests++; if (memctl_op !== MEM_LOAD) begin fails++; $display("FAIL rs_op%0d: got %0h want %0h", k, memctl_op, MEM_LOAD); end
      tests++; if (memctl_addr !== exp_addr) begin fails++; $display("FAIL rs_addr%0d: got %0h want %0h", k, memctl_addr, exp_addr); end
      tests++; if (dbg_state !== IF_WAIT) begin fails++; $display("FAIL rs_state%0d: got %0h want %0h", k, dbg_state, IF_WAIT); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rs_valid%0d: got %0b want 0", k, out_valid); end
    end
    rdy = 1'b1;
    wait_got(7, "rs_post");
    for (int k = 0; k < 7; k++) begin
      tests++; if (got_pc_q[k] !== 32'(k * 4)) begin fails++; $display("FAIL rs_pc%0d: got %0h want %0h", k, got_pc_q[k], k * 4); end
    end
  endtask

  task automatic test_wrap();
    lat = 3; out_ready = 1'b0;
    do_reset();
    wait_got2(3, "wrap");
    tests++; if (got2_q[0] !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_pc0: got %0h want fffffff8", got2_q[0]); end
    tests++; if (got2_q[1] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc1: got %0h want fffffffc", got2_q[1]); end
    tests++; if (got2_q[2] !== 32'h0) begin fails++; $display("FAIL wrap_pc2: got %0h want 0", got2_q[2]); end
    wait_load2("drop_load");
    jump2_en = 1'b1; jump2_pc = 32'h40;
    tick(1);
    jump2_en = 1'b0;
    tests++; if (dbg_state2 !== IF_DROP) begin fails++; $display("FAIL drop_state: got %0h want %0h", dbg_state2, IF_DROP); end
    rst = 1'b1;
    tick(1);
    tests++; if (dbg_state2 !== IF_IDLE) begin fails++; $display("FAIL drop_rst_state: got %0h want %0h", dbg_state2, IF_IDLE); end
    tests++; if (memctl_op2 !== MEM_NOP) begin fails++; $display("FAIL drop_rst_op: got %0h want %0h", memctl_op2, MEM_NOP); end
    tests++; if (memctl_addr2 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL drop_rst_addr: got %0h want fffffff8", memctl_addr2); end
    do_reset();
    wait_got2(1, "drop_refetch");
    tests++; if (got2_q[0] !== 32'hFFFF_FFF8) begin fails++; $display("FAIL drop_refetch_pc: got %0h want fffffff8", got2_q[0]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_jump_wait();
    test_jump_rdy();
    test_rdy_stall();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
